down_timer_ctrl: RTL

Controller that sequences a synchronous down counter as a programmable countdown timer.
- Loads a start value, decrements once per tick, and supports pause, resume, abort and one-shot or auto-reload modes.
- Emits a one-cycle done pulse at terminal count.
- Sits between a host or FSM issuing start/pause/abort commands and the counter datapath; used wherever the design needs timed delays or periodic strobes.

---
 rtl/dtc_pkg.sv | 19 +
 rtl/dtc_down_counter.sv | 41 ++++
 rtl/down_timer_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dtc_pkg.sv
// -----------------------------------------------------------------------------
// dtc_pkg
// Shared types and constants for the down_timer_ctrl countdown timer.
//   state_t        : controller state (IDLE / RUN / PAUSE, 2'd3 illegal)
//   DTC_STATE_W    : width of the state encoding
//   DTC_WIDTH_DEF  : default counter width
// -----------------------------------------------------------------------------
package dtc_pkg;

  localparam int DTC_STATE_W   = 2;
  localparam int DTC_WIDTH_DEF = 4;

  typedef enum logic [DTC_STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/dtc_down_counter.sv
// -----------------------------------------------------------------------------
// dtc_down_counter
// WIDTH-bit synchronous down counter used as the timer datapath.
//   i_clk      : rising-edge clock
//   i_reset    : synchronous active-high reset, count -> all ones
//   i_load     : load i_load_val (has priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one
//   o_count    : current count
//   o_is_one   : high when the count equals 1 (next decrement is terminal)
// -----------------------------------------------------------------------------
module dtc_down_counter
  import dtc_pkg::*;
#(
  parameter int WIDTH = DTC_WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_is_one
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '1;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count  = r_count;
  assign o_is_one = (r_count == WIDTH'(1));

endmodule

// File: rtl/down_timer_ctrl.sv
// -----------------------------------------------------------------------------
// down_timer_ctrl
// Programmable countdown timer controller: load, decrement per tick, pause,
// resume, abort, one-shot or auto-reload, one-cycle done pulse at terminal
// count.
//
// Build option: DTC_PRESCALE_EN -- when defined, a prescaler produces a tick
// every PRESCALE clocks while running (PRESCALE parameter exists only then).
// When undefined, the counter ticks every clock in RUN.
//
// Ports:
//   i_clk         : rising-edge clock
//   i_reset       : synchronous active-high reset
//   i_start       : IDLE: load and run; RUN: restart; PAUSE: resume
//   i_pause       : RUN -> PAUSE (count frozen)
//   i_abort       : any state -> IDLE, count held, no done
//   i_auto_reload : periodic mode, sampled on load
//   i_load_val    : start value, sampled on load
//   o_count       : current counter value
//   o_busy        : high in RUN or PAUSE
//   o_paused      : high in PAUSE
//   o_done        : one-cycle pulse at terminal count
//
// state | meaning
// IDLE  | stopped, count holds last value, waiting for start
// RUN   | counting down once per tick
// PAUSE | frozen, start resumes without reload
// -----------------------------------------------------------------------------
module down_timer_ctrl
  import dtc_pkg::*;
#(
  parameter int WIDTH = DTC_WIDTH_DEF
`ifdef DTC_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_abort,
  input  logic             i_auto_reload,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_paused,
  output logic             o_done
);

  state_t           r_state;
  logic             r_busy;
  logic             r_paused;
  logic             r_done;
  logic [WIDTH-1:0] r_reload;
  logic             r_auto;

  logic             w_tick;
  logic             w_is_one;
  logic             w_start_ld;
  logic             w_term;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic [WIDTH-1:0] w_cnt_val;

`ifdef DTC_PRESCALE_EN
  localparam int PRE_W = $clog2(PRESCALE);
  logic [PRE_W-1:0] r_pre;

  assign w_tick = (r_pre == PRE_W'(PRESCALE - 1));

  // Any command, a tick, or not running restarts the prescale window so the
  // first decrement after load or resume lands a full PRESCALE clocks later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre <= '0;
    end else if (r_state != RUN || i_abort || i_pause || i_start || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Counter control; priority abort > pause > start > tick.
  always_comb begin
    w_start_ld = 1'b0;
    w_term     = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_val  = i_load_val;
    case (r_state)
      IDLE: w_start_ld = i_start && !i_abort;
      RUN: begin
        if (!i_abort && !i_pause) begin
          if (i_start) begin
            w_start_ld = 1'b1;
          end else if (w_tick) begin
            w_term = w_is_one;
            if (w_is_one && r_auto) begin
              // reload straight from 1 so a 0 is never shown in periodic mode
              w_cnt_load = 1'b1;
              w_cnt_val  = r_reload;
            end else begin
              w_cnt_en = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (w_start_ld) begin
      w_cnt_load = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_paused <= 1'b0;
      r_done   <= 1'b0;
      r_reload <= '0;
      r_auto   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ld) begin
        r_reload <= i_load_val;
        r_auto   <= i_auto_reload;
      end
      case (r_state)
        IDLE: begin
          if (w_start_ld) begin
            if (i_load_val == '0) begin
              // zero load is an immediate terminal event, timer never runs
              r_done <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (i_pause) begin
            r_state  <= PAUSE;
            r_paused <= 1'b1;
          end else if (w_start_ld) begin
            // restart masks any terminal event; a zero restart just stops
            if (i_load_val == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_term) begin
            r_done <= 1'b1;
            if (!r_auto) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (i_abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_paused <= 1'b0;
          end else if (i_start) begin
            r_state  <= RUN;
            r_paused <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_paused <= 1'b0;
        end
      endcase
    end
  end

  dtc_down_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_count    (o_count),
    .o_is_one   (w_is_one)
  );

  assign o_busy   = r_busy;
  assign o_paused = r_paused;
  assign o_done   = r_done;

endmodule
